// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the round-robin arbiter: state encodings and defaults.
// Optional feature macro used by this block: ARB_TIMEOUT_EN.
package rr_arbiter8_pkg;

    localparam int unsigned ARB_N_DEF           = 8;
    localparam int unsigned ARB_TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin pick: lowest request at or above ptr, else lowest overall.
module rr_pick #(
    parameter  int unsigned N    = 8,
    localparam int unsigned IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    win_oh,
    output logic [IDXW-1:0] win_idx,
    output logic            win_vld
);

    logic [N-1:0]    mask;
    logic [N-1:0]    req_m;
    logic [IDXW-1:0] idx_m;
    logic [IDXW-1:0] idx_u;
    logic            vld_m;
    logic            vld_u;

    // Two-pass priority encode: masked (bits >= ptr) wins over the unmasked wrap-around pass.
    always_comb begin
        mask  = '0;
        idx_m = '0;
        idx_u = '0;
        vld_m = 1'b0;
        vld_u = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            mask[i] = (IDXW'(i) >= ptr);
        end
        req_m = req & mask;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_m[i]) begin
                idx_m = IDXW'(i);
                vld_m = 1'b1;
            end
            if (req[i]) begin
                idx_u = IDXW'(i);
                vld_u = 1'b1;
            end
        end
        win_vld = vld_u;
        win_idx = vld_m ? idx_m : idx_u;
        win_oh  = vld_u ? (N'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, binary index and one-cycle gap
// between owners. Define ARB_TIMEOUT_EN to add a forced release after TIMEOUT_CYC cycles.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned N = ARB_N_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld,
    output logic                 timeout
);

    localparam int unsigned IDXW = $clog2(N);

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic [N-1:0]    gnt_d;
    logic [IDXW-1:0] idx_d;
    logic            vld_d;
    logic            to_d;
    logic            rel_c;
    logic            hit_c;

    logic [N-1:0]    pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    // Owner gives the resource back by pulsing done or dropping its request.
    assign rel_c = done || !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT_CYC);

    logic [CNTW-1:0] hold_q;

    // Hold counter: zero outside GRANT, counts cycles spent in GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (state_q == ST_GRANT) begin
            hold_q <= hold_q + CNTW'(1);
        end else begin
            hold_q <= '0;
        end
    end

    assign hit_c = (state_q == ST_GRANT) && (hold_q == CNTW'(TIMEOUT_CYC - 1));

    // Timeout pulse accompanies a release that only the counter caused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= to_d;
        end
    end
`else
    assign hit_c   = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        vld_d   = gnt_vld;
        to_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    vld_d   = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel_c || hit_c) begin
                    ptr_d   = gnt_idx + IDXW'(1);
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    to_d    = hit_c && !rel_c;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                gnt_d   = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
            gnt_vld <= vld_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_rr_arbiter8;

    localparam int N = 8;
`ifdef ARB_TIMEOUT_EN
    localparam int  TCYC  = 4;
    localparam bit  TO_EN = 1'b1;
`else
    localparam int  TCYC  = 16;
    localparam bit  TO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         gnt_vld;
    logic         timeout;

    int n_pass  = 0;
    int n_total = 0;

`ifdef ARB_TIMEOUT_EN
    rr_arbiter8 #(.N(N), .TIMEOUT_CYC(TCYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );
`else
    rr_arbiter8 #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       vld;
        int         idx;
    } vec_t;

    // Behavioural model: owner (-1 when none), pointer, cycles held, gap flag.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_gap;
    bit m_to;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endtask

    // Advance the model across one rising edge given the inputs seen at that edge.
    task automatic model_step(input logic [7:0] r, input logic d);
        m_to = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
            if (m_owner >= 0) m_held = 1;
        end else begin
            bit normal;
            normal = d || !r[m_owner];
            if (normal || (TO_EN && m_held == TCYC)) begin
                m_to    = !normal;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_out(input string name, input logic vld, input int idx, input logic to);
        logic [7:0] eg;
        eg = vld ? (8'd1 << idx) : 8'd0;
        chk({name, ".gnt"}, 32'(gnt), 32'(eg));
        chk({name, ".gnt_idx"}, 32'(gnt_idx), vld ? 32'(idx) : 32'd0);
        chk({name, ".gnt_vld"}, 32'(gnt_vld), 32'(vld));
        chk({name, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst_n = 1'b0;
        req   = r;
        done  = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t vecs[20];

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;

        // Reset with every requester active; first grant after release goes to 0.
        do_reset(8'hFF);
        step();
        chk_out("first_grant", 1'b1, 0, 1'b0);
        do_reset(8'h00);

        // Cycle-by-cycle vector table from reset (ptr=0).
        vecs[0]  = '{8'h04, 1'b0, 1'b1, 2};
        vecs[1]  = '{8'h04, 1'b1, 1'b0, 0};
        vecs[2]  = '{8'h04, 1'b0, 1'b0, 0};
        vecs[3]  = '{8'h04, 1'b0, 1'b1, 2};
        vecs[4]  = '{8'h04, 1'b1, 1'b0, 0};
        vecs[5]  = '{8'hFF, 1'b0, 1'b0, 0};
        vecs[6]  = '{8'hFF, 1'b0, 1'b1, 3};
        vecs[7]  = '{8'hFF, 1'b0, 1'b1, 3};
        vecs[8]  = '{8'hF7, 1'b0, 1'b0, 0};
        vecs[9]  = '{8'h21, 1'b0, 1'b0, 0};
        vecs[10] = '{8'h21, 1'b0, 1'b1, 5};
        vecs[11] = '{8'h21, 1'b1, 1'b0, 0};
        vecs[12] = '{8'h21, 1'b0, 1'b0, 0};
        vecs[13] = '{8'h21, 1'b0, 1'b1, 0};
        vecs[14] = '{8'h20, 1'b1, 1'b0, 0};
        vecs[15] = '{8'h21, 1'b1, 1'b0, 0};
        vecs[16] = '{8'h21, 1'b1, 1'b1, 5};
        vecs[17] = '{8'h00, 1'b0, 1'b0, 0};
        vecs[18] = '{8'h00, 1'b0, 1'b0, 0};
        vecs[19] = '{8'h00, 1'b0, 1'b0, 0};
        for (int v = 0; v < 20; v++) begin
            req  = vecs[v].req;
            done = vecs[v].done;
            step();
            chk_out($sformatf("vec%0d", v), vecs[v].vld, vecs[v].idx, 1'b0);
        end
        done = 1'b0;

        // Full rotation with all requesting: 0..7,0 with exactly one gap cycle.
        do_reset(8'hFF);
        for (int k = 0; k <= N; k++) begin
            step();
            chk_out($sformatf("rot%0d", k), 1'b1, k % N, 1'b0);
            done = 1'b1;
            step();
            done = 1'b0;
            chk_out($sformatf("rot%0d_rel", k), 1'b0, 0, 1'b0);
            step();
            chk_out($sformatf("rot%0d_gap", k), 1'b0, 0, 1'b0);
        end

        // Async reset mid-grant: outputs drop before the next edge, ptr returns to 0.
        do_reset(8'h00);
        req = 8'h08;
        step();
        chk_out("ar_g3", 1'b1, 3, 1'b0);
        req = 8'h00;
        step();
        step();
        req = 8'h20;
        step();
        chk_out("ar_g5", 1'b1, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("ar_async", 1'b0, 0, 1'b0);
        req = 8'hFF;
        step();
        rst_n = 1'b1;
        step();
        chk_out("ar_ptr0", 1'b1, 0, 1'b0);

        // Long hold with no release: forced release only with the timeout feature.
        do_reset(8'h00);
        req = 8'h80;
        step();
        chk_out("hold_g7", 1'b1, 7, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c < TCYC; c++) begin
            step();
            chk_out($sformatf("to_hold%0d", c), 1'b1, 7, 1'b0);
        end
        step();
        chk_out("to_fire", 1'b0, 0, 1'b1);
        step();
        chk_out("to_gap", 1'b0, 0, 1'b0);
`else
        for (int c = 1; c < 20; c++) begin
            step();
            chk_out($sformatf("hold%0d", c), 1'b1, 7, 1'b0);
        end
`endif

        // Randomized traffic against the model.
        do_reset(8'h00);
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            req  = r;
            done = ($urandom_range(0, 5) == 0);
            model_step(req, done);
            step();
            chk_out("rand", m_owner >= 0, (m_owner >= 0) ? m_owner : 0, m_to);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
